id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register with capture-time write-back bypass, EX-stage
//   operand forwarding (EX/MEM over MEM/WB, x0 never forwarded) and
//   load-use hazard detection.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   stall, flush             hold the register / load a bubble (flush wins)
//   id_*                     decoded instruction from the ID stage
//   exmem_*, memwb_*         forwarding sources (write enable, rd, result)
//   alu_a, alu_b,
//   alu_control              operands and opcode presented to the ALU
//   ex_valid, ex_reg_write,
//   ex_mem_read,
//   ex_mem_write, ex_rd      registered controls of the EX instruction
//   ex_store_data            forwarded rs2 value for stores
//   load_use_stall           combinational hazard request to fetch/decode
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [3:0]        id_alu_control,
  input  logic              exmem_reg_write,
  input  logic [4:0]        exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [4:0]        memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_control,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              load_use_stall
);

  localparam logic [3:0] ALU_ADD = 4'b0010;

  // Registered EX-stage fields that are not ports themselves
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [DATA_W-1:0] ex_rs1_data;
  logic [DATA_W-1:0] ex_rs2_data;
  logic [DATA_W-1:0] ex_imm;
  logic              ex_alu_src;
  logic [3:0]        ex_alu_ctl;

  // Capture-time bypass: the register file write in WB happens in the same
  // cycle the ID stage reads it, so the WB result overrides the stale read.
  logic [DATA_W-1:0] cap_rs1_data;
  logic [DATA_W-1:0] cap_rs2_data;
  logic              capture;

  // Capture operands with write-back bypass applied
  always_comb begin
    cap_rs1_data = id_rs1_data;
    cap_rs2_data = id_rs2_data;
    if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == id_rs1)) begin
      cap_rs1_data = memwb_result;
    end else begin
      cap_rs1_data = id_rs1_data;
    end
    if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == id_rs2)) begin
      cap_rs2_data = memwb_result;
    end else begin
      cap_rs2_data = id_rs2_data;
    end
  end

  // A real instruction is loaded only when neither flushed nor invalid
  assign capture = id_valid && !flush;

  // ID/EX register: flush beats stall; stall holds everything; otherwise
  // load either the instruction or a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_rd        <= 5'd0;
      ex_rs1       <= 5'd0;
      ex_rs2       <= 5'd0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_alu_src   <= 1'b0;
      ex_alu_ctl   <= ALU_ADD;
    end else if (flush || !stall) begin
      ex_valid     <= capture;
      ex_reg_write <= capture ? id_reg_write   : 1'b0;
      ex_mem_read  <= capture ? id_mem_read    : 1'b0;
      ex_mem_write <= capture ? id_mem_write   : 1'b0;
      ex_rd        <= capture ? id_rd          : 5'd0;
      ex_rs1       <= capture ? id_rs1         : 5'd0;
      ex_rs2       <= capture ? id_rs2         : 5'd0;
      ex_rs1_data  <= capture ? cap_rs1_data   : '0;
      ex_rs2_data  <= capture ? cap_rs2_data   : '0;
      ex_imm       <= capture ? id_imm         : '0;
      ex_alu_src   <= capture ? id_alu_src     : 1'b0;
      ex_alu_ctl   <= capture ? id_alu_control : ALU_ADD;
    end
  end

  logic [DATA_W-1:0] rs1_fwd;
  logic [DATA_W-1:0] rs2_fwd;

  // EX forwarding on the registered source numbers; the newer EX/MEM result
  // wins, x0 is never forwarded and a bubble never forwards
  always_comb begin
    rs1_fwd = ex_rs1_data;
    rs2_fwd = ex_rs2_data;
    if (ex_valid && exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_rs1)) begin
      rs1_fwd = exmem_result;
    end else if (ex_valid && memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_rs1)) begin
      rs1_fwd = memwb_result;
    end else begin
      rs1_fwd = ex_rs1_data;
    end
    if (ex_valid && exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_rs2)) begin
      rs2_fwd = exmem_result;
    end else if (ex_valid && memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_rs2)) begin
      rs2_fwd = memwb_result;
    end else begin
      rs2_fwd = ex_rs2_data;
    end
  end

  assign alu_a         = rs1_fwd;
  assign alu_b         = ex_alu_src ? ex_imm : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign alu_control   = ex_alu_ctl;

  // A load in EX whose destination is read by the instruction in ID
  assign load_use_stall = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                          ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule
